vga_timing_gen: RTL and testbench

//  Parameterised VGA raster timing generator; the stage directly upstream of the game/pixel logic.

---
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parameterised VGA raster timing generator. Divides clk down to a pixel
//   strobe, walks a horizontal/vertical counter pair over the full raster and
//   produces sync pulses, the visible-area flag, line/frame strobes and a frame
//   counter. Every output is registered and describes the CounterX/CounterY
//   presented in the same cycle.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous reset, active low
//   en             in   run enable; low freezes the raster (strobes read 0)
//   pix_ce         out  one-clk pulse on the first clk of each new pixel
//   CounterX       out  current pixel column, 0..H_TOTAL-1
//   CounterY       out  current line, 0..V_TOTAL-1
//   inDisplayArea  out  CounterX < H_ACTIVE && CounterY < V_ACTIVE
//   vga_h_sync     out  horizontal sync, active level H_POL
//   vga_v_sync     out  vertical sync, active level V_POL
//   line_start     out  pix_ce && CounterX == 0
//   frame_start    out  pix_ce && CounterX == 0 && CounterY == 0
//   frame_count    out  frames started since reset, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int   CLK_DIV  = 2,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0,
   parameter int   XW       = 10,
   parameter int   YW       = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic          pix_ce,
   output logic [XW-1:0] CounterX,
   output logic [YW-1:0] CounterY,
   output logic          inDisplayArea,
   output logic          vga_h_sync,
   output logic          vga_v_sync,
   output logic          line_start,
   output logic          frame_start,
   output logic [15:0]   frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // A one-bit divider is kept even for CLK_DIV=1; it simply never leaves 0.
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] X_ACT_END  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] X_SYNC_BEG = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] X_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] Y_ACT_END  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] Y_SYNC_BEG = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] Y_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] divCnt;
   logic          advance;
   logic [XW-1:0] nextX;
   logic [YW-1:0] nextY;
   logic          nextAtOrigin;
   logic          nextDisp;
   logic          nextHSync;
   logic          nextVSync;

   // ---- pixel divider ------------------------------------------------------
   assign advance = en && (divCnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divCnt <= '0;
      end else if (en) begin
         divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + DW'(1);
      end
   end

   // ---- next raster position and its decode --------------------------------
   // Flags are decoded from the position being entered so that, once
   // registered, they line up with the counters in the same cycle.
   always_comb begin
      nextX = CounterX;
      nextY = CounterY;
      if (CounterX == X_LAST) begin
         nextX = '0;
         nextY = (CounterY == Y_LAST) ? '0 : CounterY + YW'(1);
      end else begin
         nextX = CounterX + XW'(1);
      end

      nextAtOrigin = (nextX == '0) && (nextY == '0);
      nextDisp     = (nextX < X_ACT_END) && (nextY < Y_ACT_END);
      nextHSync    = ((nextX >= X_SYNC_BEG) && (nextX < X_SYNC_END)) ? H_POL : ~H_POL;
      nextVSync    = ((nextY >= Y_SYNC_BEG) && (nextY < Y_SYNC_END)) ? V_POL : ~V_POL;
   end

   // ---- registered raster state --------------------------------------------
   // Reset parks on the last blanking pixel so the first advance lands on
   // (0,0) and raises frame_start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         CounterX      <= X_LAST;
         CounterY      <= Y_LAST;
         inDisplayArea <= 1'b0;
         vga_h_sync    <= ~H_POL;
         vga_v_sync    <= ~V_POL;
         frame_count   <= '0;
      end else if (advance) begin
         CounterX      <= nextX;
         CounterY      <= nextY;
         inDisplayArea <= nextDisp;
         vga_h_sync    <= nextHSync;
         vga_v_sync    <= nextVSync;
         if (nextAtOrigin) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

   // ---- per-pixel strobes ---------------------------------------------------
   // High for exactly the clk after an advance edge; zero whenever en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_ce      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_ce      <= advance;
         line_start  <= advance && (nextX == '0);
         frame_start <= advance && nextAtOrigin;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   typedef struct {
      int hDiv;
      int ha, hfp, hs, hbp;
      int va, vfp, vs, vbp;
      int hpol, vpol;
   } cfg_t;

   typedef struct {
      logic [31:0] x, y, ce, disp, hs, vs, ls, fs, fc;
   } obs_t;

   typedef struct {
      int clks;
      int en;
      int x, y, ce, disp, hs, vs, ls, fs, fc;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   int checks = 0;
   int errors = 0;

   // instance A: standard 640x480, CLK_DIV=2, active-low syncs
   logic        aCe, aDisp, aHs, aVs, aLs, aFs;
   logic [9:0]  aX, aY;
   logic [15:0] aFc;
   // instance B: tiny raster, CLK_DIV=1, active-high syncs
   logic        bCe, bDisp, bHs, bVs, bLs, bFs;
   logic [3:0]  bX;
   logic [2:0]  bY;
   logic [15:0] bFc;
   // instance C: tiny raster, CLK_DIV=3, mixed sync polarity
   logic        cCe, cDisp, cHs, cVs, cLs, cFs;
   logic [3:0]  cX;
   logic [2:0]  cY;
   logic [15:0] cFc;

   always #5 clk = ~clk;

   vga_timing_gen dutA (
      .clk(clk), .rst_n(rst_n), .en(en), .pix_ce(aCe), .CounterX(aX), .CounterY(aY),
      .inDisplayArea(aDisp), .vga_h_sync(aHs), .vga_v_sync(aVs), .line_start(aLs),
      .frame_start(aFs), .frame_count(aFc)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1),
      .XW(4), .YW(3)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .en(en), .pix_ce(bCe), .CounterX(bX), .CounterY(bY),
      .inDisplayArea(bDisp), .vga_h_sync(bHs), .vga_v_sync(bVs), .line_start(bLs),
      .frame_start(bFs), .frame_count(bFc)
   );

   vga_timing_gen #(
      .CLK_DIV(3), .H_ACTIVE(5), .H_FP(2), .H_SYNC(1), .H_BP(2),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2), .H_POL(1'b1), .V_POL(1'b0),
      .XW(4), .YW(3)
   ) dutC (
      .clk(clk), .rst_n(rst_n), .en(en), .pix_ce(cCe), .CounterX(cX), .CounterY(cY),
      .inDisplayArea(cDisp), .vga_h_sync(cHs), .vga_v_sync(cVs), .line_start(cLs),
      .frame_start(cFs), .frame_count(cFc)
   );

   cfg_t   cfgs [3];
   longint nAdv [3];   // pixel advances since reset
   longint enClk[3];   // enabled clocks since reset
   bit     mCe  [3];   // an advance happened on the last edge

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic obs_t getObs(input int i);
      obs_t o;
      o = '{default: '0};
      case (i)
         0: begin
            o.x = 32'(aX); o.y = 32'(aY); o.ce = 32'(aCe); o.disp = 32'(aDisp);
            o.hs = 32'(aHs); o.vs = 32'(aVs); o.ls = 32'(aLs); o.fs = 32'(aFs); o.fc = 32'(aFc);
         end
         1: begin
            o.x = 32'(bX); o.y = 32'(bY); o.ce = 32'(bCe); o.disp = 32'(bDisp);
            o.hs = 32'(bHs); o.vs = 32'(bVs); o.ls = 32'(bLs); o.fs = 32'(bFs); o.fc = 32'(bFc);
         end
         default: begin
            o.x = 32'(cX); o.y = 32'(cY); o.ce = 32'(cCe); o.disp = 32'(cDisp);
            o.hs = 32'(cHs); o.vs = 32'(cVs); o.ls = 32'(cLs); o.fs = 32'(cFs); o.fc = 32'(cFc);
         end
      endcase
      return o;
   endfunction

   // Reference: the raster position is simply the number of pixel advances
   // since reset, offset by one (reset sits on the last pixel of the frame).
   function automatic obs_t expectObs(input int i);
      obs_t   e;
      cfg_t   c;
      longint ht, vt, tot, pos, x, y;
      bit     hAct, vAct;
      c   = cfgs[i];
      ht  = c.ha + c.hfp + c.hs + c.hbp;
      vt  = c.va + c.vfp + c.vs + c.vbp;
      tot = ht * vt;
      pos = (nAdv[i] + tot - 1) % tot;
      x   = pos % ht;
      y   = pos / ht;
      hAct = (x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hs);
      vAct = (y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vs);
      e.x    = 32'(x);
      e.y    = 32'(y);
      e.ce   = mCe[i] ? 32'd1 : 32'd0;
      e.disp = (x < c.ha && y < c.va) ? 32'd1 : 32'd0;
      e.hs   = 32'(hAct ? c.hpol : 1 - c.hpol);
      e.vs   = 32'(vAct ? c.vpol : 1 - c.vpol);
      e.ls   = (mCe[i] && x == 0) ? 32'd1 : 32'd0;
      e.fs   = (mCe[i] && pos == 0) ? 32'd1 : 32'd0;
      e.fc   = 32'(((nAdv[i] + tot - 1) / tot) % 65536);
      return e;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         nAdv[i] = 0; enClk[i] = 0; mCe[i] = 1'b0;
      end
   endtask

   task automatic modelEdge();
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            nAdv[i] = 0; enClk[i] = 0; mCe[i] = 1'b0;
         end else if (en) begin
            mCe[i] = ((enClk[i] % cfgs[i].hDiv) == cfgs[i].hDiv - 1);
            enClk[i]++;
            if (mCe[i]) nAdv[i]++;
         end else begin
            mCe[i] = 1'b0;
         end
      end
   endtask

   task automatic checkAll();
      obs_t e, o;
      for (int i = 0; i < 3; i++) begin
         e = expectObs(i);
         o = getObs(i);
         cmp($sformatf("model%0d X", i),     o.x,    e.x);
         cmp($sformatf("model%0d Y", i),     o.y,    e.y);
         cmp($sformatf("model%0d pix_ce", i), o.ce,  e.ce);
         cmp($sformatf("model%0d disp", i),  o.disp, e.disp);
         cmp($sformatf("model%0d hsync", i), o.hs,   e.hs);
         cmp($sformatf("model%0d vsync", i), o.vs,   e.vs);
         cmp($sformatf("model%0d line_start", i),  o.ls, e.ls);
         cmp($sformatf("model%0d frame_start", i), o.fs, e.fs);
         cmp($sformatf("model%0d frame_count", i), o.fc, e.fc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
   endtask

   task automatic checkResetA(input string tag);
      cmp({tag, " X"}, 32'(aX), 32'd799);
      cmp({tag, " Y"}, 32'(aY), 32'd524);
      cmp({tag, " hsync"}, 32'(aHs), 32'd1);
      cmp({tag, " vsync"}, 32'(aVs), 32'd1);
      cmp({tag, " disp"}, 32'(aDisp), 32'd0);
      cmp({tag, " pix_ce"}, 32'(aCe), 32'd0);
      cmp({tag, " frame_start"}, 32'(aFs), 32'd0);
      cmp({tag, " frame_count"}, 32'(aFc), 32'd0);
      cmp({tag, " B hsync idle"}, 32'(bHs), 32'd0);
      cmp({tag, " B vsync idle"}, 32'(bVs), 32'd0);
   endtask

   vec_t vecs [15];

   initial begin
      obs_t o;

      cfgs[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
      cfgs[1] = '{1, 6, 1, 2, 1, 4, 1, 2, 1, 1, 1};
      cfgs[2] = '{3, 5, 2, 1, 2, 3, 1, 1, 2, 1, 0};

      //          clks  en  x    y    ce disp hs vs ls fs fc
      vecs[0]  = '{1,    1, 799, 524, 0, 0,   1, 1, 0, 0, 0};
      vecs[1]  = '{1,    1, 0,   0,   1, 1,   1, 1, 1, 1, 1};
      vecs[2]  = '{1,    1, 0,   0,   0, 1,   1, 1, 0, 0, 1};
      vecs[3]  = '{1,    1, 1,   0,   1, 1,   1, 1, 0, 0, 1};
      vecs[4]  = '{1276, 1, 639, 0,   1, 1,   1, 1, 0, 0, 1};
      vecs[5]  = '{2,    1, 640, 0,   1, 0,   1, 1, 0, 0, 1};
      vecs[6]  = '{30,   1, 655, 0,   1, 0,   1, 1, 0, 0, 1};
      vecs[7]  = '{2,    1, 656, 0,   1, 0,   0, 1, 0, 0, 1};
      vecs[8]  = '{190,  1, 751, 0,   1, 0,   0, 1, 0, 0, 1};
      vecs[9]  = '{2,    1, 752, 0,   1, 0,   1, 1, 0, 0, 1};
      vecs[10] = '{94,   1, 799, 0,   1, 0,   1, 1, 0, 0, 1};
      vecs[11] = '{2,    1, 0,   1,   1, 1,   1, 1, 1, 0, 1};
      vecs[12] = '{1,    0, 0,   1,   0, 1,   1, 1, 0, 0, 1};
      vecs[13] = '{200,  1, 100, 1,   1, 1,   1, 1, 0, 0, 1};
      vecs[14] = '{1,    1, 100, 1,   0, 1,   1, 1, 0, 0, 1};

      // reset held
      rst_n = 1'b0;
      en    = 1'b0;
      modelReset();
      repeat (3) tick();
      checkResetA("reset");

      // release with en=1 and walk line 0 into line 1
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         en = (vecs[k].en != 0);
         repeat (vecs[k].clks) tick();
         o = getObs(0);
         cmp($sformatf("vec%0d X", k),           o.x,    32'(vecs[k].x));
         cmp($sformatf("vec%0d Y", k),           o.y,    32'(vecs[k].y));
         cmp($sformatf("vec%0d pix_ce", k),      o.ce,   32'(vecs[k].ce));
         cmp($sformatf("vec%0d disp", k),        o.disp, 32'(vecs[k].disp));
         cmp($sformatf("vec%0d hsync", k),       o.hs,   32'(vecs[k].hs));
         cmp($sformatf("vec%0d vsync", k),       o.vs,   32'(vecs[k].vs));
         cmp($sformatf("vec%0d line_start", k),  o.ls,   32'(vecs[k].ls));
         cmp($sformatf("vec%0d frame_start", k), o.fs,   32'(vecs[k].fs));
         cmp($sformatf("vec%0d frame_count", k), o.fc,   32'(vecs[k].fc));
      end

      // freeze for 37 clks at X=100 (divider held mid-pixel)
      en = 1'b0;
      for (int k = 0; k < 37; k++) begin
         tick();
         cmp("freeze X", 32'(aX), 32'd100);
         cmp("freeze Y", 32'(aY), 32'd1);
         cmp("freeze pix_ce", 32'(aCe), 32'd0);
         cmp("freeze B pix_ce", 32'(bCe), 32'd0);
      end
      en = 1'b1;
      tick();
      cmp("resume X101", 32'(aX), 32'd101);
      cmp("resume ce", 32'(aCe), 32'd1);
      tick();
      cmp("resume hold X", 32'(aX), 32'd101);
      tick();
      cmp("resume X102", 32'(aX), 32'd102);

      // asynchronous reset mid-line, then fresh frame
      rst_n = 1'b0;
      #1;
      modelReset();
      checkResetA("async reset");
      checkAll();
      tick();
      tick();
      rst_n = 1'b1;
      en    = 1'b1;
      tick();
      cmp("restart hold X", 32'(aX), 32'd799);
      tick();
      cmp("restart X", 32'(aX), 32'd0);
      cmp("restart Y", 32'(aY), 32'd0);
      cmp("restart frame_start", 32'(aFs), 32'd1);
      cmp("restart frame_count", 32'(aFc), 32'd1);

      // randomized enable with occasional asynchronous resets
      for (int k = 0; k < 20000; k++) begin
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1499) == 0) begin
            rst_n = 1'b0;
            #2;
            modelReset();
            checkAll();
            rst_n = 1'b1;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
